arm_mc_controller: RTL and testbench
====================================

Name: arm_mc_controller

Overview:
- Control unit for the ARM multicycle datapath: main FSM, ALU decoder, instruction decoder and conditional-execution logic with the NZCV flags register.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable: PC, instruction register, address mux, SrcA/SrcB muxes, result mux, register file, memory write.
- Supports data-processing (ADD/SUB/AND/ORR, register or immediate), LDR/STR with immediate offset, and B.

Parameters:
- RESET_STATE, 4'd0 (FETCH): FSM state entered on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  Instr[31:12] from instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 A, 01 PC
- ALUSrcB  out  2  00 WriteData, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Halted  out  1  trap indicator (see Optional Feature); tied 0 when feature absent

Behaviour:
- Reset (reset=0, asynchronous):
  - State = FETCH, Flags = 4'b0000, condex_q = 0.
  - All enables (PCWrite, MemWrite, IRWrite, RegWrite) = 0 while reset is held; selects take their FETCH values.
  - Deasserting reset mid-instruction restarts at FETCH; partial instructions are not resumed.
- States and transitions:
  - FETCH -> DECODE
  - DECODE:
    - Op=00, Funct[5]=0 -> EXECUTER
    - Op=00, Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (treated as NOP)
  - MEMADR: Funct[0]=1 -> MEMREAD, Funct[0]=0 -> MEMWRITE
  - MEMREAD -> MEMWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH
  - EXECUTER, EXECUTEI -> ALUWB
- Per-state raw controls (anything unlisted is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=00, ALUSrcB=01
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWRITE: AdrSrc=1, MemW=1
  - EXECUTER: ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1 (suppressed if cmd unsupported)
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1
- ALU decode:
  - ALUOp=0 -> ADD.
  - ALUOp=1 -> Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - Any other cmd -> ADD with RegW and FlagW forced to 0.
- Conditional execution:
  - CondEx is evaluated combinationally in DECODE from Cond and the Flags register.
  - Codes 0000-1110 per ARM (EQ..AL); 1111 -> false.
  - CondEx is latched into condex_q at the end of DECODE.
- Gating:
  - RegWrite = RegW & condex_q
  - MemWrite = MemW & condex_q
  - PCS = Branch | (RegW & Rd==4'hF)
  - PCWrite = NextPC | (PCS & condex_q)
  - In FETCH and DECODE, gating does not depend on condex_q.
- Flags update, at the rising edge ending EXECUTER/EXECUTEI, only when Funct[0]=1 (S) and condex_q=1:
  - NZ <= ALUFlags[3:2]
  - CV <= ALUFlags[1:0], only when ALUControl is ADD or SUB
- Instruction latency: DP = 4 cycles, LDR = 5, STR = 4, B = 3.
- Outputs are combinational from state, Instr and condex_q; state and flags are the only registers.

Optional Feature:
- Macro: MC_UNDEF_TRAP_EN.
- Defined:
  - DECODE with Op=11 enters TRAP.
  - TRAP holds all enables at 0 and asserts Halted=1 until reset.
  - TRAP ignores Instr and flags.
- Undefined: Op=11 returns to FETCH as a NOP; Halted is constant 0.

Decomposition:
- Package arm_mc_pkg holds:
  - statetype enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, TRAP)
  - Op codes (OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10)
  - ALU control constants
  - ResultSrc/ALUSrcA/ALUSrcB select constants
- Sub-module: arm_mc_condlogic, containing the flags register, CondEx evaluation, condex_q, and write-enable/PCWrite gating.
- The FSM and decoders stay in the top.

Test Plan:
- Release reset after 3 cycles, Instr=ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000, Rd=1):
  - FETCH/DECODE/EXECUTER/ALUWB in order.
  - IRWrite=1 and PCWrite=1 only in cycle 1; RegWrite=1 only in ALUWB.
  - ALUControl=00 in EXECUTER.
- SUBS Rd=2 with ALUFlags=0100 in EXECUTEI:
  - Flags become 0100.
  - Next BEQ (Cond=0000, Op=10): PCWrite=1 in BRANCH, 3 cycles total.
- BNE with Flags Z=1: BRANCH state entered, PCWrite=0 in BRANCH, next state FETCH.
- LDR (Op=01, Funct[0]=1):
  - 5-cycle sequence; AdrSrc=1 in MEMREAD.
  - ResultSrc=01 and RegWrite=1 in MEMWB.
- STR with Cond=EQ and Z=0: MEMWRITE reached, MemWrite stays 0.
- ADD with Rd=15: PCWrite=1 in ALUWB. Separately, reset asserted mid-EXECUTER -> state FETCH immediately, Flags=0000.

Source files
------------

// File: rtl/arm_mc_controller_pkg.sv
// Shared types and constants for the ARM multicycle control unit.
// The optional undefined-instruction trap is enabled by the macro MC_UNDEF_TRAP_EN.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } statetype;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_A  = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;

  localparam logic [1:0] SRCB_WD  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // ARM condition-code evaluation against an NZCV nibble; 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = ~(n ^ v);
      4'b1011: cond_pass = n ^ v;
      4'b1100: cond_pass = ~z & ~(n ^ v);
      4'b1101: cond_pass = z | (n ^ v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle. master = control unit, slave = datapath.
// Handshake: none; all signals are level-valid every cycle, no valid/ready.
interface arm_mc_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;
  logic        Halted;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Halted
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Halted
  );
endinterface

// File: rtl/arm_mc_controller_condlogic.sv
// NZCV flags register, condition evaluation, latched CondEx and enable gating.
module arm_mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       cond_latch_i,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Branch,
  input  logic       NextPC,
  input  logic       rd_is_pc_i,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q;
  logic       condex_q;
  logic       condex_d;
  logic       pcs;

  assign condex_d = cond_pass(Cond, flags_q);

  // CondEx captured at the end of DECODE; flags written at the end of execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (cond_latch_i) condex_q <= condex_d;
      if (FlagW[1] & condex_q) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & condex_q) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Raw controls are all zero in DECODE and only NextPC is set in FETCH,
  // so a stale condex_q from the previous instruction never leaks through.
  always_comb begin
    pcs      = Branch | (RegW & rd_is_pc_i);
    RegWrite = reset & RegW & condex_q;
    MemWrite = reset & MemW & condex_q;
    PCWrite  = reset & (NextPC | (pcs & condex_q));
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/arm_mc_controller.sv
// ARM multicycle control unit: main FSM, ALU and instruction decoders.
// Define MC_UNDEF_TRAP_EN to make Op=11 halt in TRAP instead of acting as a NOP.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  arm_mc_if.master   bus,
  output logic [3:0] dbg_state_o,
  output logic [3:0] dbg_flags_o
);

  statetype   state_q, state_d;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;

  logic       next_pc, irw, adr, alu_op, regw_raw, regw, memw, branch;
  logic [1:0] srca, srcb, res, alu_ctl, flag_w;
  logic       cmd_ok;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
`ifdef MC_UNDEF_TRAP_EN
          default: state_d = TRAP;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
`ifdef MC_UNDEF_TRAP_EN
      TRAP:     state_d = TRAP;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // State register; any reset restarts the instruction from FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= statetype'(RESET_STATE);
    else        state_q <= state_d;
  end

  // ALU command decode; unsupported commands fall back to ADD and write nothing.
  always_comb begin
    cmd_ok  = 1'b1;
    alu_ctl = ALU_ADD;
    case (funct[4:1])
      4'b0100: alu_ctl = ALU_ADD;
      4'b0010: alu_ctl = ALU_SUB;
      4'b0000: alu_ctl = ALU_AND;
      4'b1100: alu_ctl = ALU_ORR;
      default: cmd_ok  = 1'b0;
    endcase
    flag_w[1] = alu_op & funct[0] & cmd_ok;
    flag_w[0] = flag_w[1] & ((alu_ctl == ALU_ADD) | (alu_ctl == ALU_SUB));
  end

  // Per-state raw controls, before condition gating.
  always_comb begin
    next_pc  = 1'b0;
    irw      = 1'b0;
    adr      = 1'b0;
    alu_op   = 1'b0;
    regw_raw = 1'b0;
    memw     = 1'b0;
    branch   = 1'b0;
    srca     = SRCA_A;
    srcb     = SRCB_WD;
    res      = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        irw = 1'b1; next_pc = 1'b1;
        srca = SRCA_PC; srcb = SRCB_4; res = RES_ALURESULT;
      end
      DECODE: begin
        srca = SRCA_PC; srcb = SRCB_4; res = RES_ALURESULT;
      end
      MEMADR:   srcb = SRCB_IMM;
      MEMREAD:  adr = 1'b1;
      MEMWB: begin
        res = RES_DATA; regw_raw = 1'b1;
      end
      MEMWRITE: begin
        adr = 1'b1; memw = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        srcb = SRCB_IMM; alu_op = 1'b1;
      end
      ALUWB:    regw_raw = 1'b1;
      BRANCH: begin
        srcb = SRCB_IMM; res = RES_ALURESULT; branch = 1'b1;
      end
      default: ;
    endcase
    regw = regw_raw & ~((state_q == ALUWB) & ~cmd_ok);
  end

  arm_mc_condlogic u_cond (
    .clk          (clk),
    .reset        (reset),
    .Cond         (cond),
    .ALUFlags     (bus.ALUFlags),
    .FlagW        (flag_w),
    .cond_latch_i (state_q == DECODE),
    .RegW         (regw),
    .MemW         (memw),
    .Branch       (branch),
    .NextPC       (next_pc),
    .rd_is_pc_i   (rd == 4'hF),
    .RegWrite     (bus.RegWrite),
    .MemWrite     (bus.MemWrite),
    .PCWrite      (bus.PCWrite),
    .flags_o      (dbg_flags_o)
  );

  assign bus.IRWrite    = irw & reset;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = res;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ALUControl = alu_op ? alu_ctl : ALU_ADD;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
`ifdef MC_UNDEF_TRAP_EN
  assign bus.Halted     = (state_q == TRAP);
`else
  assign bus.Halted     = 1'b0;
`endif
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: directed plan then random program.
module tb_arm_mc_controller;
  import arm_mc_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] dbg_state;
  logic [3:0] dbg_flags;
  int         n_checks;
  int         n_fail;
  logic [3:0] mflags;

  arm_mc_if ifc();

  arm_mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc),
    .dbg_state_o (dbg_state),
    .dbg_flags_o (dbg_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: condition codes by ARM mnemonic
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;                  // EQ
      4'd1:  return !z;                 // NE
      4'd2:  return cy;                 // CS
      4'd3:  return !cy;                // CC
      4'd4:  return n;                  // MI
      4'd5:  return !n;                 // PL
      4'd6:  return v;                  // VS
      4'd7:  return !v;                 // VC
      4'd8:  return cy && !z;           // HI
      4'd9:  return !cy || z;           // LS
      4'd10: return n == v;             // GE
      4'd11: return n != v;             // LT
      4'd12: return !z && (n == v);     // GT
      4'd13: return z || (n != v);      // LE
      4'd14: return 1'b1;               // AL
      default: return 1'b0;
    endcase
  endfunction

  // expected control word {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,SrcA,SrcB,ALUControl,Halted}
  function automatic logic [13:0] exp_ctrl(input statetype st, input bit pass, input bit ok,
                                           input bit rd15, input logic [1:0] aluc);
    logic pcw, irw, rw, mw, adr, hlt;
    logic [1:0] res, sa, sb, ac;
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; hlt = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; ac = 2'b00;
    case (st)
      FETCH:    begin pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
      DECODE:   begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
      MEMADR:   sb = 2'b01;
      MEMREAD:  adr = 1;
      MEMWB:    begin res = 2'b01; rw = pass; pcw = pass && rd15; end
      MEMWRITE: begin adr = 1; mw = pass; end
      EXECUTER: ac = aluc;
      EXECUTEI: begin sb = 2'b01; ac = aluc; end
      ALUWB:    begin rw = pass && ok; pcw = pass && ok && rd15; end
      BRANCH:   begin sb = 2'b01; res = 2'b10; pcw = pass; end
      TRAP:     hlt = 1;
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, res, sa, sb, ac, hlt};
  endfunction

  function automatic logic [13:0] obs_ctrl();
    return {ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite, ifc.AdrSrc, ifc.ResultSrc,
            ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl, ifc.Halted};
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] d);
    return {c, o, f, 4'h2, d};
  endfunction

  // driver: run one instruction from FETCH, checking every cycle against the model
  task automatic run_instr(input string name, input logic [19:0] ins,
                           input bit fix_af, input logic [3:0] af);
    logic [3:0] c, d, cmd, used_af;
    logic [1:0] o, aluc;
    logic [5:0] f;
    bit pass, ok;
    statetype seq[$];
    c = ins[19:16]; o = ins[15:14]; f = ins[13:8]; d = ins[3:0]; cmd = f[4:1];
    pass = model_cond(c, mflags);
    ok = 1; aluc = 2'b00;
    case (cmd)
      4'b0100: aluc = 2'b00;
      4'b0010: aluc = 2'b01;
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      default: ok = 0;
    endcase
    case (o)
      2'b00:   seq = '{FETCH, DECODE, (f[5] ? EXECUTEI : EXECUTER), ALUWB};
      2'b01:   seq = f[0] ? '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB}
                          : '{FETCH, DECODE, MEMADR, MEMWRITE};
      2'b10:   seq = '{FETCH, DECODE, BRANCH};
`ifdef MC_UNDEF_TRAP_EN
      default: seq = '{FETCH, DECODE, TRAP, TRAP, TRAP};
`else
      default: seq = '{FETCH, DECODE};
`endif
    endcase
    ifc.Instr = ins;
    foreach (seq[k]) begin
      used_af = fix_af ? af : 4'($urandom_range(0, 15));
      ifc.ALUFlags = used_af;
      @(negedge clk);
      chk($sformatf("%s.state%0d", name, k), 32'(dbg_state), 32'(seq[k]));
      chk($sformatf("%s.ctrl%0d", name, k), 32'(obs_ctrl()),
          32'(exp_ctrl(seq[k], pass, ok, d == 4'hF, aluc)));
      if (seq[k] == DECODE) begin
        chk($sformatf("%s.immsrc", name), 32'(ifc.ImmSrc), 32'(o));
        chk($sformatf("%s.regsrc", name), 32'(ifc.RegSrc), 32'({o == 2'b01, o == 2'b10}));
      end
      @(posedge clk); #1;
      if ((seq[k] == EXECUTER || seq[k] == EXECUTEI) && pass && f[0] && ok) begin
        mflags[3:2] = used_af[3:2];
        if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = used_af[1:0];
      end
    end
    chk($sformatf("%s.flags", name), 32'(dbg_flags), 32'(mflags));
  endtask

  initial begin
    logic [19:0] ri;
    logic [1:0]  rop;
    n_checks = 0; n_fail = 0; mflags = 4'b0000;
    reset = 1'b0; ifc.Instr = '0; ifc.ALUFlags = '0;

    // reset held three cycles: enables off, FETCH selects, flags clear
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.state", 32'(dbg_state), 32'(FETCH));
    chk("rst.ctrl", 32'(obs_ctrl()), 32'(14'b0_0_0_0_0_10_01_10_00_0));
    chk("rst.flags", 32'(dbg_flags), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // directed plan
    run_instr("add",   mk(4'hE, 2'b00, 6'b001000, 4'd1), 1, 4'b1111);
    run_instr("subs",  mk(4'hE, 2'b00, 6'b100101, 4'd2), 1, 4'b0100);
    chk("subs.z", 32'(dbg_flags), 32'h4);
    run_instr("beq",   mk(4'h0, 2'b10, 6'b000011, 4'd0), 0, 4'b0);
    run_instr("bne",   mk(4'h1, 2'b10, 6'b110000, 4'd0), 0, 4'b0);
    run_instr("ldr",   mk(4'hE, 2'b01, 6'b011001, 4'd3), 0, 4'b0);
    run_instr("adds0", mk(4'hE, 2'b00, 6'b001001, 4'd4), 1, 4'b0000);
    run_instr("streq", mk(4'h0, 2'b01, 6'b011000, 4'd5), 0, 4'b0);
    run_instr("addpc", mk(4'hE, 2'b00, 6'b001000, 4'hF), 0, 4'b0);
    run_instr("ands",  mk(4'hE, 2'b00, 6'b100001, 4'd6), 1, 4'b1111);
    run_instr("undef", mk(4'hE, 2'b00, 6'b010101, 4'd7), 1, 4'b1111);
    run_instr("never", mk(4'hF, 2'b00, 6'b001001, 4'hF), 1, 4'b0101);
`ifndef MC_UNDEF_TRAP_EN
    run_instr("nop",   mk(4'hE, 2'b11, 6'b000000, 4'd0), 0, 4'b0);
`endif
    run_instr("adds1", mk(4'hE, 2'b00, 6'b001001, 4'd1), 1, 4'b1111);

    // reset asserted mid-EXECUTER
    ifc.Instr = mk(4'hE, 2'b00, 6'b001001, 4'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst.pre", 32'(dbg_state), 32'(EXECUTER));
    reset = 1'b0; #1;
    chk("midrst.state", 32'(dbg_state), 32'(FETCH));
    chk("midrst.flags", 32'(dbg_flags), 32'h0);
    chk("midrst.en", 32'({ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite}), 32'h0);
    mflags = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b1;

    // random program
    for (int i = 0; i < 60; i++) begin
`ifdef MC_UNDEF_TRAP_EN
      rop = 2'($urandom_range(0, 2));
`else
      rop = 2'($urandom_range(0, 3));
`endif
      ri = mk(4'($urandom_range(0, 15)), rop, 6'($urandom_range(0, 63)),
              ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
      run_instr($sformatf("rnd%0d", i), ri, 0, 4'b0);
    end
    @(negedge clk);
    chk("end.state", 32'(dbg_state), 32'(FETCH));

`ifdef MC_UNDEF_TRAP_EN
    // undefined op halts until reset
    run_instr("trap", mk(4'hE, 2'b11, 6'b000000, 4'hF), 0, 4'b0);
    reset = 1'b0; #1;
    chk("trap.rst", 32'(dbg_state), 32'(FETCH));
    @(posedge clk); #1;
    reset = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
